// File: rtl/eight_by_four_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eight_by_four_divider_pkg
//  Description : Shared widths, FSM state encoding and divide-by-zero
//                constants for the 8-by-4 sequential restoring divider.
//  Revision    : 1.0  initial release
// ============================================================================
package eight_by_four_divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    // Partial remainder carries one guard bit above the divisor width
    localparam int PREM_W     = DIVISOR_W + 1;
    localparam int CNT_W      = 3;

    // Explicit FSM encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_e;

    // Quotient reported when the divisor is zero
    localparam logic [DIVIDEND_W-1:0] DBZ_QUOT = 8'hFF;

    // Counter value loaded on accept; counts down to zero over 8 iterations
    localparam logic [CNT_W-1:0] CNT_FIRST = 3'd7;
    localparam logic [CNT_W-1:0] CNT_LAST  = 3'd0;

endpackage : eight_by_four_divider_pkg
`default_nettype wire

// File: rtl/eight_by_four_divider_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : five_bit_trial_subtractor
//  Description : Combinational 5-bit trial subtraction for one restoring
//                division step. borrow_o = 0 means the minuend is at least
//                the subtrahend, so the difference is kept (no restore).
//  Revision    : 1.0  initial release
// ============================================================================
module five_bit_trial_subtractor
    import eight_by_four_divider_pkg::*;
(
    input  logic [PREM_W-1:0] minuend_i,
    input  logic [PREM_W-1:0] subtrahend_i,
    output logic [PREM_W-1:0] diff_o,
    output logic              borrow_o
);

    logic [PREM_W:0] w_full;

    // Widen by one bit so the MSB of the result is the borrow out
    always_comb begin
        w_full   = {1'b0, minuend_i} - {1'b0, subtrahend_i};
        diff_o   = w_full[PREM_W-1:0];
        borrow_o = w_full[PREM_W];
    end

endmodule : five_bit_trial_subtractor
`default_nettype wire

// File: rtl/eight_by_four_divider.sv
`default_nettype none
// ============================================================================
//  Module      : eight_by_four_divider
//  Description : Sequential restoring divider, 8-bit unsigned dividend by
//                4-bit unsigned divisor, one quotient bit per clock behind a
//                start/done handshake. Exact golden model for approximate
//                dividers. Divide by zero answers in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module eight_by_four_divider
    import eight_by_four_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] in1,
    input  logic [DIVISOR_W-1:0]  in2,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  div_by_zero
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;     // dividend shift register
    logic [PREM_W-1:0]       dvs_q, dvs_d;     // zero-extended divisor
    logic [PREM_W-1:0]       prem_q, prem_d;   // partial remainder
    logic [DIVIDEND_W-1:0]   sq_q, sq_d;       // shadow quotient
    logic [DIVIDEND_W-1:0]   quot_q, quot_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic                    dbz_q, dbz_d;

    logic [PREM_W-1:0]       w_trial;
    logic [PREM_W-1:0]       w_diff;
    logic                    w_borrow;
    logic                    w_unused_prem_msb;

    // Remainder stays below the divisor, so the guard bit is always zero
    // after an iteration and only the low bits feed the next trial.
    assign w_trial           = {prem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    assign w_unused_prem_msb = prem_q[PREM_W-1];

    five_bit_trial_subtractor u_trial_sub (
        .minuend_i    (w_trial),
        .subtrahend_i (dvs_q),
        .diff_o       (w_diff),
        .borrow_o     (w_borrow)
    );

    // Next-state, datapath and result logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        sq_d    = sq_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (in2 == '0) begin
                        // No iteration: saturated quotient, low dividend bits
                        quot_d  = DBZ_QUOT;
                        rem_d   = in1[DIVISOR_W-1:0];
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        dvd_d   = in1;
                        dvs_d   = {1'b0, in2};
                        prem_d  = '0;
                        cnt_d   = CNT_FIRST;
                        dbz_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                dvd_d  = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                prem_d = w_borrow ? w_trial : w_diff;
                sq_d   = {sq_q[DIVIDEND_W-2:0], ~w_borrow};
                if (cnt_q == CNT_LAST) begin
                    quot_d  = sq_d;
                    rem_d   = prem_d[DIVISOR_W-1:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            sq_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            sq_q    <= sq_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Status flags decode directly from the state register
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule : eight_by_four_divider
`default_nettype wire
